// File: rtl/lcd_pkg.sv
// Shared types and bit positions for the character-LCD controller.
// Imported by the command FIFO and the controller top.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_BLON_BIT = 30;
  localparam int LCD_CTRL_BIT = 9;
  localparam int LCD_RS_BIT   = 8;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long(input lcd_cmd_t c);
    return !c.rs && (c.data[7:2] == 6'd0) && (c.data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO of queued LCD commands.
// A push into a full FIFO is only taken when a pop frees a slot.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  lcd_cmd_t din,
  output lcd_cmd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  lcd_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        do_push & ~do_pop: count <= count + 1'b1;
        do_pop & ~do_push: count <= count - 1'b1;
        default:           count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// Memory-mapped HD44780-style LCD controller: queues CPU stores
// and sequences setup, enable pulse, hold and execution waits.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 1,
  parameter int T_EXEC  = 2000,
  parameter int T_LONG  = 80000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_wr_en,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_status,
  output logic        o_lcd_on,
  output logic        o_lcd_blon,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data
);

  localparam int T_MAX = (T_LONG > T_EXEC) ? T_LONG : T_EXEC;
  localparam int CW    = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_EN    = CW'(T_EN - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] C_LONG  = CW'(T_LONG - 1);

  lcd_state_e    state;
  logic [CW-1:0] cnt;
  lcd_cmd_t      cmd;
  lcd_cmd_t      head;
  lcd_cmd_t      wr_cmd;
  logic          en_q;
  logic          on_q;
  logic          blon_q;
  logic          ovf_q;
  logic          is_ctrl;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_wdata;

  assign is_ctrl      = i_wdata[LCD_CTRL_BIT];
  assign push         = i_wr_en & ~is_ctrl;
  assign pop          = (state == IDLE) & ~fifo_empty;
  assign wr_cmd       = {i_wdata[LCD_RS_BIT], i_wdata[7:0]};
  assign unused_wdata = ^i_wdata[29:10];

  lcd_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .push  (push),
    .pop   (pop),
    .din   (wr_cmd),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Power/backlight latch on every store; sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      on_q   <= 1'b0;
      blon_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (i_wr_en) begin
      on_q   <= i_wdata[LCD_ON_BIT];
      blon_q <= i_wdata[LCD_BLON_BIT];
      if (is_ctrl)
        ovf_q <= 1'b0;
      else if (fifo_full & ~pop)
        ovf_q <= 1'b1;
    end
  end

  // Bus sequencer: setup, enable pulse, hold, then execution wait.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      cnt   <= '0;
      cmd   <= '0;
      en_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            cmd   <= head;
            cnt   <= C_SETUP;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            en_q  <= 1'b1;
            cnt   <= C_EN;
            state <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            en_q  <= 1'b0;
            cnt   <= C_HOLD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long(cmd) ? C_LONG : C_EXEC;
            state <= EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC: begin
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        default: begin
          en_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Status word for the load-store read mux.
  always_comb begin
    o_status                = '0;
    o_status[STAT_BUSY_BIT] = (state != IDLE) | ~fifo_empty;
    o_status[STAT_FULL_BIT] = fifo_full;
    o_status[STAT_OVF_BIT]  = ovf_q;
  end

  assign o_lcd_on   = on_q;
  assign o_lcd_blon = blon_q;
  assign o_lcd_rs   = cmd.rs;
  assign o_lcd_data = cmd.data;
  assign o_lcd_en   = en_q;
  assign o_lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened bus timing.
// Logs every EN pulse (command and width) from the LCD pins.
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] status;
  logic        lcd_on;
  logic        lcd_blon;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic [7:0]  lcd_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] log_cmd [$];
  int         log_len [$];
  logic       en_prev = 1'b0;
  int         run = 0;

  lcd_ctrl #(
    .DEPTH   (4),
    .T_SETUP (2),
    .T_EN    (4),
    .T_HOLD  (1),
    .T_EXEC  (10),
    .T_LONG  (50)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_wr_en    (wr_en),
    .i_wdata    (wdata),
    .o_status   (status),
    .o_lcd_on   (lcd_on),
    .o_lcd_blon (lcd_blon),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lcd_en) begin
      if (!en_prev) begin
        log_cmd.push_back({lcd_rs, lcd_data});
        run = 1;
      end else begin
        run++;
      end
    end else if (en_prev) begin
      log_len.push_back(run);
    end
    en_prev = lcd_en;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] w);
    wr_en = 1'b1;
    wdata = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound && status[0]; i++) tick();
    chk({tag, "_idle"}, status[0], 0);
  endtask

  task automatic clr_log();
    log_cmd.delete();
    log_len.delete();
  endtask

  initial begin
    #12;
    chk("rst_status", status, 0);
    chk("rst_en", lcd_en, 0);
    chk("rst_on", lcd_on, 0);
    chk("rst_data", {lcd_rs, lcd_data}, 0);
    chk("rst_rw", lcd_rw, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // 1: single data write
    clr_log();
    wr(32'h8000_0141);
    chk("t1_on", lcd_on, 1);
    chk("t1_status", status, 1);
    chk("t1_nodata", lcd_data, 0);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 1) begin
        chk("t1_data", lcd_data, 8'h41);
        chk("t1_rs", lcd_rs, 1);
      end
      chk("t1_en", lcd_en, (k >= 3 && k <= 6));
      chk("t1_busy", status[0], (k < 18));
    end
    chk("t1_npulse", log_cmd.size(), 1);
    chk("t1_width", log_len[0], 4);

    // 2: clear then function-set
    clr_log();
    wr_en = 1'b1;
    wdata = 32'h0000_0001;
    tick();
    wdata = 32'h0000_0038;
    for (int k = 1; k <= 76; k++) begin
      tick();
      if (k == 1) wr_en = 1'b0;
      if (k == 58) chk("t2_data58", lcd_data, 8'h01);
      if (k == 59) chk("t2_data59", {lcd_rs, lcd_data}, 9'h038);
      chk("t2_en", lcd_en,
          (k >= 3 && k <= 6) || (k >= 61 && k <= 64));
      chk("t2_busy", status[0], (k < 76));
    end
    chk("t2_npulse", log_cmd.size(), 2);
    chk("t2_cmd1", log_cmd[1], 9'h038);

    // 3+4: overflow, then control write clears it
    clr_log();
    for (int i = 0; i < 6; i++) wr(32'h130 + i);
    chk("t3_status", status, 7);
    wr(32'h4000_0200);
    chk("t4_status", status, 3);
    chk("t4_blon", lcd_blon, 1);
    chk("t4_on", lcd_on, 0);
    wait_idle("t3", 300);
    chk("t3_npulse", log_cmd.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_cmd", log_cmd[i], 32'h130 + i);
      chk("t3_width", log_len[i], 4);
    end

    // 6: push into full FIFO in the pop cycle
    clr_log();
    for (int i = 0; i < 5; i++) wr(32'h150 + i);
    repeat (14) tick();
    chk("t6_pre", status, 3);
    wr(32'h1AA);
    chk("t6_post", status, 3);
    wait_idle("t6", 300);
    chk("t6_npulse", log_cmd.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("t6_cmd", log_cmd[i], (i < 5) ? 32'h150 + i : 32'h1AA);

    // 5: reset in the middle of the enable pulse
    wr(32'hC000_0141);
    wr(32'h8000_0142);
    tick();
    tick();
    chk("t5_en_pre", lcd_en, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_en", lcd_en, 0);
    chk("t5_status", status, 0);
    chk("t5_pwr", {lcd_on, lcd_blon}, 0);
    chk("t5_bus", {lcd_rs, lcd_data}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    clr_log();
    repeat (40) tick();
    chk("t5_npulse", log_cmd.size(), 0);
    chk("t5_idle", status, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
